p2s_shifter: RTL and testbench
==============================

P2S_SHIFTER -- requirements
Module: p2s_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, setting the register width; legal values are 2 and above.
REQ-002 The block SHALL have parameter DIV, default 1, setting the clocks per serial bit; legal values are 1 and above.
REQ-003 The block SHALL have parameter MSB_FIRST, default 1: 1 serialises from bit WIDTH-1 downward, 0 from bit 0 upward.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 s1, s0  in  1 each  mode select for register mode.
REQ-007 sr_in  in  1  serial input for right shift.
REQ-008 sl_in  in  1  serial input for left shift.
REQ-009 d  in  WIDTH  parallel load data.
REQ-010 start  in  1  one-cycle request to serialise d.
REQ-011 q  out  WIDTH  register contents.
REQ-012 ser_out  out  1  serial data bit.
REQ-013 ser_valid  out  1  high while ser_out carries a frame bit.
REQ-014 busy  out  1  serialiser active.
REQ-015 done  out  1  one-cycle frame-complete pulse.

Function
REQ-016 The block SHALL be a state machine with states IDLE, SHIFT and DONE; all outputs SHALL be registered.
REQ-017 In IDLE with start=0, {s1,s0} SHALL act on every edge as follows:
- 00: hold q.
- 01: q <= {sr_in, q[WIDTH-1:1]}.
- 10: q <= {q[WIDTH-2:0], sl_in}.
- 11: q <= d.
REQ-018 In IDLE with start=1, at the same edge the block SHALL:
- load q <= d;
- enter SHIFT;
- set busy=1 and ser_valid=1;
- drive ser_out = d[WIDTH-1] if MSB_FIRST, else d[0].
start SHALL take priority over {s1,s0}.
REQ-019 In SHIFT, each bit SHALL be held for exactly DIV clocks, counted by a divider counter.
REQ-020 At the end of each bit period q SHALL shift toward the output end, filling with 0, and the next bit SHALL appear on ser_out.
REQ-021 Exactly WIDTH bits SHALL be emitted, tracked by a bit counter of width clog2(WIDTH+1).
REQ-022 At edge k+WIDTH*DIV, where k is the start edge, the block SHALL enter DONE with done=1, busy=0 and ser_valid=0.
REQ-023 At that edge ser_out SHALL be 0 and q SHALL be all-zero.
REQ-024 DONE SHALL last one cycle, clear done and return to IDLE; {s1,s0} and start SHALL be ignored during DONE.
REQ-025 In SHIFT, start and {s1,s0} SHALL be ignored; no frame restart or abort exists apart from reset.
REQ-026 With DIV=1 the block SHALL emit one bit per clock with no gap cycles.
REQ-027 A start asserted in the cycle after DONE SHALL begin a new frame normally.
REQ-028 In IDLE, ser_out and ser_valid SHALL be 0.

Reset
REQ-029 While rst_n=0, the following SHALL be held at 0 and the state SHALL be IDLE:
- q (all bits) and ser_out;
- ser_valid, busy and done;
- both counters.
This SHALL take effect immediately, independent of clk.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no done pulse.
REQ-031 The first edge after rst_n rises SHALL be processed as IDLE.

Verification
REQ-032 Load/shift, WIDTH=64: {s1,s0}=11, d=64'h8421842184218421, one edge -> q=64'h8421842184218421.
REQ-033 Then {s1,s0}=01, sr_in=1, one edge -> q=64'hC210C210C210C210.
REQ-034 Then {s1,s0}=10, sl_in=0, one edge -> q=64'h8421842184218420.
REQ-035 Serialise, WIDTH=8, DIV=1, MSB_FIRST=1, d=8'hA5, start pulse:
- ser_out = 1,0,1,0,0,1,0,1 on consecutive clocks, busy=1 for 8 clocks;
- done=1 on clock 9, q=0.
REQ-036 Divider, WIDTH=8, DIV=3, MSB_FIRST=0, d=8'h01:
- ser_out=1 for 3 clocks, then 0 for 21 clocks;
- done at edge k+24.
REQ-037 Priority/ignore, WIDTH=8, DIV=1:
- start=1 with {s1,s0}=01 in IDLE -> frame starts and no shift is applied;
- start re-pulsed mid-frame -> no effect, exactly one done.
REQ-038 Reset mid-frame: rst_n low in cycle 4 of a frame -> q=0 and busy=ser_valid=0 immediately, no done, IDLE after release.

Source files
------------

// File: rtl/p2s_shifter.sv
// Parallel-to-serial shifter with a general-purpose register mode.
// In idle the register behaves as a universal shift register selected by {s1,s0};
// a start pulse loads d and serialises it, one bit every DIV clocks, then pulses done.
module p2s_shifter #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned DIV       = 1,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s1,
  input  logic             s0,
  input  logic             sr_in,
  input  logic             sl_in,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] BitLast = CntW'(WIDTH - 1);
  localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DivW-1:0]  div_cnt_q, div_cnt_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] q_drained;

  // Next-state, register datapath and registered-output values
  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    ser_out_d   = ser_out_q;
    ser_valid_d = ser_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    // Register moved one place toward the serial output end, zero filled
    q_drained   = (MSB_FIRST != 0) ? {q_q[WIDTH-2:0], 1'b0} : {1'b0, q_q[WIDTH-1:1]};

    unique case (state_q)
      StIdle: begin
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        busy_d      = 1'b0;
        div_cnt_d   = '0;
        bit_cnt_d   = '0;
        if (start) begin
          // start wins over the register mode select
          q_d         = d;
          state_d     = StShift;
          busy_d      = 1'b1;
          ser_valid_d = 1'b1;
          ser_out_d   = (MSB_FIRST != 0) ? d[WIDTH-1] : d[0];
        end else begin
          case ({s1, s0})
            2'b01:   q_d = {sr_in, q_q[WIDTH-1:1]};
            2'b10:   q_d = {q_q[WIDTH-2:0], sl_in};
            2'b11:   q_d = d;
            default: q_d = q_q;
          endcase
        end
      end
      StShift: begin
        if (div_cnt_q == DivLast) begin
          div_cnt_d = '0;
          q_d       = q_drained;
          if (bit_cnt_q == BitLast) begin
            // Last bit period over: register is fully drained
            state_d     = StDone;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            ser_valid_d = 1'b0;
            ser_out_d   = 1'b0;
            q_d         = '0;
            bit_cnt_d   = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            ser_out_d = (MSB_FIRST != 0) ? q_drained[WIDTH-1] : q_drained[0];
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d     = StIdle;
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      q_q         <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  assign q         = q_q;
  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_p2s_shifter.sv
// Self-checking bench for p2s_shifter: register modes on a 64-bit instance, framing on an
// 8-bit MSB-first DIV=1 instance and an 8-bit LSB-first DIV=3 instance.
module tb_p2s_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s1, s0, sr_in, sl_in;
  logic [63:0] d64;
  logic [7:0]  d8;
  logic        start64, start_m, start_l;

  logic [63:0] q64;
  logic        ser64, val64, busy64, done64;
  logic [7:0]  q_m, q_l;
  logic        ser_m, val_m, busy_m, done_m;
  logic        ser_l, val_l, busy_l, done_l;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  p2s_shifter u_w64 (
    .clk(clk), .rst_n(rst_n), .s1(s1), .s0(s0), .sr_in(sr_in), .sl_in(sl_in),
    .d(d64), .start(start64), .q(q64), .ser_out(ser64), .ser_valid(val64),
    .busy(busy64), .done(done64)
  );

  p2s_shifter #(.WIDTH(8), .DIV(1), .MSB_FIRST(1)) u_msb8 (
    .clk(clk), .rst_n(rst_n), .s1(s1), .s0(s0), .sr_in(sr_in), .sl_in(sl_in),
    .d(d8), .start(start_m), .q(q_m), .ser_out(ser_m), .ser_valid(val_m),
    .busy(busy_m), .done(done_m)
  );

  p2s_shifter #(.WIDTH(8), .DIV(3), .MSB_FIRST(0)) u_lsb8 (
    .clk(clk), .rst_n(rst_n), .s1(s1), .s0(s0), .sr_in(sr_in), .sl_in(sl_in),
    .d(d8), .start(start_l), .q(q_l), .ser_out(ser_l), .ser_valid(val_l),
    .busy(busy_l), .done(done_l)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read one 8-bit instance: status packed as {busy, ser_valid, done, ser_out}
  task automatic sample(input int sel, output logic [7:0] oq, output logic [3:0] ost);
    if (sel == 0) begin
      oq  = q_m;
      ost = {busy_m, val_m, done_m, ser_m};
    end else begin
      oq  = q_l;
      ost = {busy_l, val_l, done_l, ser_l};
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; s1 = 0; s0 = 0; sr_in = 0; sl_in = 0;
    d64 = '0; d8 = '0; start64 = 0; start_m = 0; start_l = 0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({q64, ser64, val64, busy64, done64} !== 68'd0) begin
      n_fail++;
      $display("FAIL reset_w64: got q=%h st=%b%b%b%b want all 0", q64, busy64, val64, done64, ser64);
    end
    n_checks++;
    if ({q_m, busy_m, val_m, done_m, ser_m, q_l, busy_l, val_l, done_l, ser_l} !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_w8: got qm=%h ql=%h want 0 with idle flags", q_m, q_l);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({q_m, busy_m, val_m, done_m, ser_m} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_first_edge: got q=%h busy=%b want q=0 idle", q_m, busy_m);
    end
  endtask

  task automatic test_modes();
    logic [63:0] exp_q;
    // Directed load / right / left sequence
    {s1, s0} = 2'b11; d64 = 64'h8421842184218421;
    tick();
    n_checks++;
    if (q64 !== 64'h8421842184218421) begin
      n_fail++; $display("FAIL mode_load: got %h want 8421842184218421", q64);
    end
    {s1, s0} = 2'b01; sr_in = 1'b1;
    tick();
    n_checks++;
    if (q64 !== 64'hC210C210C210C210) begin
      n_fail++; $display("FAIL mode_right: got %h want c210c210c210c210", q64);
    end
    {s1, s0} = 2'b10; sl_in = 1'b0;
    tick();
    n_checks++;
    if (q64 !== 64'h8421842184218420) begin
      n_fail++; $display("FAIL mode_left: got %h want 8421842184218420", q64);
    end
    // Random register-mode operations against an arithmetic model
    exp_q = 64'h8421842184218420;
    for (int i = 0; i < 40; i++) begin
      {s1, s0} = 2'($urandom_range(3));
      sr_in = 1'($urandom);
      sl_in = 1'($urandom);
      d64   = {$urandom, $urandom};
      case ({s1, s0})
        2'b01:   exp_q = (exp_q >> 1) | ({63'd0, sr_in} << 63);
        2'b10:   exp_q = (exp_q << 1) | {63'd0, sl_in};
        2'b11:   exp_q = d64;
        default: exp_q = exp_q;
      endcase
      tick();
      n_checks++;
      if (q64 !== exp_q || {busy64, val64, done64, ser64} !== 4'b0000) begin
        n_fail++;
        $display("FAIL mode_rand[%0d]: got q=%h st=%b%b%b%b want q=%h st=0000",
                 i, q64, busy64, val64, done64, ser64, exp_q);
      end
    end
    {s1, s0} = 2'b00;
  endtask

  // One full frame on an 8-bit instance; start is raised with {s1,s0}=01 to prove priority
  task automatic run_frame(input int sel, input logic [7:0] dv, input bit repulse, input string nm);
    int          div;
    bit          msb;
    int          idx;
    logic [7:0]  oq, eq;
    logic [3:0]  ost;
    logic        es;
    div = (sel == 0) ? 1 : 3;
    msb = (sel == 0);
    d8 = dv; {s1, s0} = 2'b01; sr_in = 1'($urandom);
    if (sel == 0) start_m = 1'b1; else start_l = 1'b1;
    tick();
    start_m = 1'b0; start_l = 1'b0;
    for (int t = 0; t < 8 * div; t++) begin
      idx = t / div;
      es  = msb ? dv[7-idx] : dv[idx];
      eq  = msb ? (dv << idx) : (dv >> idx);
      sample(sel, oq, ost);
      n_checks++;
      if (ost !== {3'b110, es} || oq !== eq) begin
        n_fail++;
        $display("FAIL %s t=%0d: got st=%b q=%h want st=%b q=%h", nm, t, ost, oq, {3'b110, es}, eq);
      end
      // Mid-frame stimulus that must be ignored
      {s1, s0} = 2'($urandom_range(3));
      d8 = 8'($urandom);
      if (repulse && t == 3) begin
        if (sel == 0) start_m = 1'b1; else start_l = 1'b1;
      end else begin
        start_m = 1'b0; start_l = 1'b0;
      end
      tick();
    end
    sample(sel, oq, ost);
    n_checks++;
    if (ost !== 4'b0010 || oq !== 8'h00) begin
      n_fail++;
      $display("FAIL %s done: got st=%b q=%h want st=0010 q=00", nm, ost, oq);
    end
    // Start and load during the done cycle are ignored
    {s1, s0} = 2'b11; d8 = 8'hFF;
    if (sel == 0) start_m = 1'b1; else start_l = 1'b1;
    tick();
    start_m = 1'b0; start_l = 1'b0; {s1, s0} = 2'b00;
    sample(sel, oq, ost);
    n_checks++;
    if (ost !== 4'b0000 || oq !== 8'h00) begin
      n_fail++;
      $display("FAIL %s post_done: got st=%b q=%h want st=0000 q=00", nm, ost, oq);
    end
  endtask

  task automatic test_serialise();
    run_frame(0, 8'hA5, 1'b0, "ser_msb_a5");
    run_frame(1, 8'h01, 1'b0, "ser_lsb_div3_01");
    for (int i = 0; i < 3; i++) begin
      run_frame(0, 8'($urandom), 1'b0, "ser_msb_rand");
      run_frame(1, 8'($urandom), 1'b0, "ser_lsb_rand");
    end
  endtask

  task automatic test_priority_ignore();
    run_frame(0, 8'($urandom), 1'b1, "repulse_msb");
    run_frame(1, 8'($urandom), 1'b1, "repulse_lsb");
  endtask

  task automatic test_back_to_back();
    run_frame(0, 8'($urandom), 1'b0, "b2b_first");
    run_frame(0, 8'($urandom), 1'b0, "b2b_second");
  endtask

  task automatic test_reset_mid_frame();
    d8 = 8'($urandom) | 8'h81;
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({q_m, busy_m, val_m, done_m, ser_m} !== 12'd0) begin
      n_fail++;
      $display("FAIL rst_mid_async: got q=%h st=%b%b%b%b want all 0", q_m, busy_m, val_m, done_m, ser_m);
    end
    tick();
    n_checks++;
    if ({q_m, busy_m, val_m, done_m, ser_m} !== 12'd0) begin
      n_fail++;
      $display("FAIL rst_mid_held: got q=%h done=%b want all 0", q_m, done_m);
    end
    rst_n = 1'b1;
    {s1, s0} = 2'b11; d8 = 8'h5A;
    tick();
    {s1, s0} = 2'b00;
    n_checks++;
    if (q_m !== 8'h5A || {busy_m, val_m, done_m, ser_m} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_mid_idle: got q=%h st=%b%b%b%b want q=5a st=0000",
               q_m, busy_m, val_m, done_m, ser_m);
    end
    run_frame(0, 8'($urandom), 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_modes();
    test_serialise();
    test_priority_ignore();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
